// File: rtl/demux_vc_bp.sv
// Registered 1-to-NUM_VC virtual-channel demultiplexer with a one-entry stall
// register for per-channel backpressure and per-channel push counters.
module demux_vc_bp #(
    parameter int DATA_SIZE = 6,
    parameter int SEL_BITS  = 1,
    parameter int SEL_LSB   = 5,
    parameter int CNT_W     = 8,
    localparam int NUM_VC   = 2 ** SEL_BITS
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      valid_in,
    input  logic [DATA_SIZE-1:0]      data_in,
    output logic                      ready_out,
    input  logic [NUM_VC-1:0]         almost_full,
    output logic [NUM_VC-1:0]         push_vc,
    output logic [DATA_SIZE-1:0]      data_vc,
    output logic                      hold_valid,
    output logic [NUM_VC*CNT_W-1:0]   push_count
);

    logic                 hold_valid_reg, hold_valid_next;
    logic [DATA_SIZE-1:0] hold_data_reg, hold_data_next;
    logic [NUM_VC-1:0]    push_vc_reg, push_vc_next;
    logic [DATA_SIZE-1:0] data_vc_reg, data_vc_next;
    logic [SEL_BITS-1:0]  in_sel, hold_sel;

    assign in_sel   = data_in[SEL_LSB +: SEL_BITS];
    assign hold_sel = hold_data_reg[SEL_LSB +: SEL_BITS];

    // A held word has priority and blocks new acceptance; only its own
    // channel's almost_full can keep it waiting.
    always_comb begin
        push_vc_next    = '0;
        data_vc_next    = '0;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        if (hold_valid_reg) begin
            if (!almost_full[hold_sel]) begin
                push_vc_next[hold_sel] = 1'b1;
                data_vc_next           = hold_data_reg;
                hold_valid_next        = 1'b0;
            end
        end else if (valid_in) begin
            if (!almost_full[in_sel]) begin
                push_vc_next[in_sel] = 1'b1;
                data_vc_next         = data_in;
            end else begin
                hold_valid_next = 1'b1;
                hold_data_next  = data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            push_vc_reg    <= '0;
            data_vc_reg    <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
            push_vc_reg    <= push_vc_next;
            data_vc_reg    <= data_vc_next;
        end
    end

    // Counters advance on the same edge that raises the push strobe, so a
    // count already includes the push currently on the bus.
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                cnt_reg <= '0;
            end else if (push_vc_next[gi]) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign push_count[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    assign ready_out  = ~hold_valid_reg;
    assign hold_valid = hold_valid_reg;
    assign push_vc    = push_vc_reg;
    assign data_vc    = data_vc_reg;

endmodule

// File: tb/tb_demux_vc_bp.sv
// Bench for demux_vc_bp: directed table, reset/throughput sequences, random
// traffic against a queue-based reference, and two alternate parameterisations.
module tb_demux_vc_bp;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        valid_in = 1'b0;
    logic [5:0]  data_in = '0;
    logic [1:0]  af = '0;
    logic        ready;
    logic [1:0]  push;
    logic [5:0]  dvc;
    logic        hold;
    logic [15:0] cnt;

    // CNT_W=2 instance
    logic        v2 = 1'b0;
    logic [5:0]  d2 = '0;
    logic [1:0]  af2 = '0;
    logic        r2, h2;
    logic [1:0]  p2;
    logic [5:0]  dv2;
    logic [3:0]  c2;

    // SEL_BITS=2, SEL_LSB=4 instance
    logic        v3 = 1'b0;
    logic [5:0]  d3 = '0;
    logic [3:0]  af3 = '0;
    logic        r3, h3;
    logic [3:0]  p3;
    logic [5:0]  dv3;
    logic [31:0] c3;

    demux_vc_bp dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready), .almost_full(af), .push_vc(push), .data_vc(dvc),
        .hold_valid(hold), .push_count(cnt)
    );

    demux_vc_bp #(.CNT_W(2)) dut_w (
        .clk(clk), .reset_L(reset_L), .valid_in(v2), .data_in(d2),
        .ready_out(r2), .almost_full(af2), .push_vc(p2), .data_vc(dv2),
        .hold_valid(h2), .push_count(c2)
    );

    demux_vc_bp #(.SEL_BITS(2), .SEL_LSB(4)) dut_s (
        .clk(clk), .reset_L(reset_L), .valid_in(v3), .data_in(d3),
        .ready_out(r3), .almost_full(af3), .push_vc(p3), .data_vc(dv3),
        .hold_valid(h3), .push_count(c3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        tick();
        reset_L = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       v;
        logic [5:0] d;
        logic [1:0] af;
        logic [1:0] ep;
        logic [5:0] ed;
        logic       eh;
    } vec_t;

    vec_t tbl[13];

    // Reference model state: words accepted but not yet pushed, and counts.
    logic [5:0] pend_q[$];
    int         mcnt[2];

    initial begin
        // routing
        tbl[0]  = '{1'b1, 6'h05, 2'b00, 2'b01, 6'h05, 1'b0};
        tbl[1]  = '{1'b1, 6'h25, 2'b00, 2'b10, 6'h25, 1'b0};
        // stall, held for 3 cycles, then released
        tbl[2]  = '{1'b1, 6'h30, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[3]  = '{1'b0, 6'h00, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[4]  = '{1'b0, 6'h00, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[5]  = '{1'b0, 6'h00, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[6]  = '{1'b0, 6'h00, 2'b00, 2'b10, 6'h30, 1'b0};
        // independence: af[0] toggles, upstream word waits its turn
        tbl[7]  = '{1'b1, 6'h30, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[8]  = '{1'b1, 6'h01, 2'b11, 2'b00, 6'h00, 1'b1};
        tbl[9]  = '{1'b1, 6'h01, 2'b10, 2'b00, 6'h00, 1'b1};
        tbl[10] = '{1'b1, 6'h01, 2'b01, 2'b10, 6'h30, 1'b0};
        tbl[11] = '{1'b1, 6'h01, 2'b00, 2'b01, 6'h01, 1'b0};
        tbl[12] = '{1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0};

        do_reset();
        chk("rst_push", push, 0);
        chk("rst_data", dvc, 0);
        chk("rst_hold", hold, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", ready, 1);

        for (int i = 0; i < 13; i++) begin
            valid_in = tbl[i].v;
            data_in  = tbl[i].d;
            af       = tbl[i].af;
            tick();
            chk($sformatf("tbl%0d_push", i), push, tbl[i].ep);
            chk($sformatf("tbl%0d_data", i), dvc, tbl[i].ed);
            chk($sformatf("tbl%0d_hold", i), hold, tbl[i].eh);
            chk($sformatf("tbl%0d_ready", i), ready, !tbl[i].eh);
        end
        chk("tbl_cnt0", cnt[7:0], 2);
        chk("tbl_cnt1", cnt[15:8], 3);

        // Asynchronous reset while a word is held
        valid_in = 1'b1; data_in = 6'h30; af = 2'b10;
        tick();
        valid_in = 1'b0;
        chk("mid_hold", hold, 1);
        #2 reset_L = 1'b0;
        #1;
        chk("arst_push", push, 0);
        chk("arst_data", dvc, 0);
        chk("arst_hold", hold, 0);
        chk("arst_cnt", cnt, 0);
        #2 reset_L = 1'b1;
        af = 2'b00;
        tick();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_push", push, 0);
        tick();
        chk("discard_push", push, 0);

        // Back-to-back throughput
        for (int k = 0; k < 8; k++) begin
            valid_in = 1'b1;
            data_in  = (k % 2 == 1) ? 6'(6'h20 | k) : 6'(k);
            af       = 2'b00;
            tick();
            chk($sformatf("tput%0d_push", k), push, (k % 2 == 1) ? 2 : 1);
            chk($sformatf("tput%0d_data", k), dvc, (k % 2 == 1) ? (32'h20 | k) : k);
        end
        valid_in = 1'b0;
        tick();
        chk("tput_idle", push, 0);
        chk("tput_cnt0", cnt[7:0], 4);
        chk("tput_cnt1", cnt[15:8], 4);

        // Random traffic against the queue model
        do_reset();
        pend_q.delete();
        mcnt[0] = 0;
        mcnt[1] = 0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0] ep;
            logic [5:0] ed;
            int s;
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 6'($urandom);
            af       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            chk($sformatf("rnd%0d_ready", n), ready, pend_q.size() == 0);
            ep = '0;
            ed = '0;
            if (pend_q.size() > 0) begin
                s = (int'(pend_q[0]) >> 5) % 2;
                if (!af[s]) begin
                    ep = 2'(1 << s);
                    ed = pend_q.pop_front();
                    mcnt[s] = (mcnt[s] + 1) % 256;
                end
            end else if (valid_in) begin
                s = (int'(data_in) >> 5) % 2;
                if (!af[s]) begin
                    ep = 2'(1 << s);
                    ed = data_in;
                    mcnt[s] = (mcnt[s] + 1) % 256;
                end else begin
                    pend_q.push_back(data_in);
                end
            end
            tick();
            chk($sformatf("rnd%0d_push", n), push, ep);
            chk($sformatf("rnd%0d_data", n), dvc, ed);
            chk($sformatf("rnd%0d_hold", n), hold, pend_q.size() != 0);
            chk($sformatf("rnd%0d_cnt0", n), cnt[7:0], mcnt[0]);
            chk($sformatf("rnd%0d_cnt1", n), cnt[15:8], mcnt[1]);
        end
        valid_in = 1'b0;
        af = 2'b00;

        // Narrow counter wraps: 5 pushes into a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            v2 = 1'b1; d2 = 6'h00; af2 = 2'b00;
            tick();
            chk($sformatf("wrap%0d_push", k), p2, 1);
        end
        v2 = 1'b0;
        tick();
        chk("wrap_cnt0", c2[1:0], 1);
        chk("wrap_cnt1", c2[3:2], 0);

        // Wider selector at a different position
        v3 = 1'b1; d3 = 6'b100000; af3 = 4'b0000;
        tick();
        chk("sel2_push", p3, 4'b0100);
        chk("sel2_data", dv3, 6'h20);
        v3 = 1'b0;
        tick();
        chk("sel2_idle", p3, 0);
        chk("sel2_cnt2", c3[23:16], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
